// File: rtl/iec_host_tx.sv
// iec_host_tx: host-side IEC talker; frames ATN commands, clocks bytes LSB first, signals EOI, checks frame ack.
// Latency: bus input edges act after 2 clk (sync) + 1 clk (state); per bit 2*T_BIT ce ticks.
// Backpressure: tx_ready only in IDLE; byte held until acked, timed out or reset. Optional: IEC_HOST_TIMEOUT_EN.
module iec_host_tx #(
  parameter int T_BIT = 60,
  parameter int T_EOI = 250,
  parameter int T_ACK = 1000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce,
  input  logic [7:0] tx_data,
  input  logic       tx_atn,
  input  logic       tx_eoi,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       atn_release,
  input  logic       iec_atn_i,
  input  logic       iec_clk_i,
  input  logic       iec_data_i,
  output logic       iec_atn_o,
  output logic       iec_clk_o,
  output logic       iec_data_o,
  output logic       busy,
  output logic       done,
  output logic       err_nodev,
  output logic       err_noack
);

  typedef enum logic [3:0] {
    IDLE, ATN_GRAB, WAIT_DEV, READY, WAIT_RFD, EOI_WAIT,
    EOI_ACK, BIT_LO, BIT_HI, FRAME, ACK_WAIT
  } state_t;

  state_t      state;
  logic [10:0] timer;
  logic [2:0]  idx;
  logic [7:0]  data_q;
  logic        eoi_q;
  logic [1:0]  atn_sync, clk_sync, data_sync;
  logic        atn_s, clk_s, data_s;

  assign atn_s  = atn_sync[1];
  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];

  // Timer reload value for each state; FRAME waits one tick so the released
  // DATA line propagates through the synchronizer before the ack is sampled.
  function automatic logic [10:0] tload(input state_t s);
    case (s)
      WAIT_DEV, ACK_WAIT: tload = 11'(T_ACK);
      EOI_WAIT:           tload = 11'(T_EOI);
      BIT_LO, BIT_HI:     tload = 11'(T_BIT);
      FRAME:              tload = 11'd1;
      default:            tload = 11'd0;
    endcase
  endfunction

  // Two-flop synchronizers for the bus levels (idle bus reads high).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      atn_sync  <= 2'b11;
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      atn_sync  <= {atn_sync[0], iec_atn_i};
      clk_sync  <= {clk_sync[0], iec_clk_i};
      data_sync <= {data_sync[0], iec_data_i};
    end
  end

  // Talker state machine with registered bus drives and status outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      timer      <= '0;
      idx        <= '0;
      data_q     <= '0;
      eoi_q      <= 1'b0;
      tx_ready   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_nodev  <= 1'b0;
      err_noack  <= 1'b0;
      iec_atn_o  <= 1'b1;
      iec_clk_o  <= 1'b1;
      iec_data_o <= 1'b1;
    end else begin
      done <= 1'b0;
      if (ce && timer != 11'd0) timer <= timer - 11'd1;
      case (state)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            data_q    <= tx_data;
            eoi_q     <= tx_eoi;
            err_nodev <= 1'b0;
            err_noack <= 1'b0;
            tx_ready  <= 1'b0;
            busy      <= 1'b1;
            if (tx_atn && iec_atn_o) begin
              state <= ATN_GRAB;
              timer <= tload(ATN_GRAB);
            end else begin
              // A data byte while ATN is still held ends the command phase.
              if (!tx_atn) iec_atn_o <= 1'b1;
              state <= READY;
              timer <= tload(READY);
            end
          end else begin
            tx_ready <= 1'b1;
            if (atn_release) begin
              iec_atn_o <= 1'b1;
              iec_clk_o <= 1'b0;
            end
          end
        end
        ATN_GRAB: begin
          iec_atn_o  <= 1'b0;
          iec_clk_o  <= 1'b0;
          iec_data_o <= 1'b1;
          state      <= WAIT_DEV;
          timer      <= tload(WAIT_DEV);
        end
        WAIT_DEV: begin
          // Presence only counts once our ATN is visible on the bus.
          if (!atn_s && !data_s) begin
            state <= READY;
            timer <= tload(READY);
          end
`ifdef IEC_HOST_TIMEOUT_EN
          else if (timer == 11'd0) begin
            err_nodev  <= 1'b1;
            iec_atn_o  <= 1'b1;
            iec_clk_o  <= 1'b1;
            iec_data_o <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
            timer      <= tload(IDLE);
          end
`endif
        end
        READY: begin
          iec_clk_o  <= 1'b1;
          iec_data_o <= 1'b1;
          state      <= WAIT_RFD;
          timer      <= tload(WAIT_RFD);
        end
        WAIT_RFD: begin
          // Wait until our CLK release is seen so DATA is not read stale.
          if (clk_s && data_s) begin
            if (eoi_q) begin
              state <= EOI_WAIT;
              timer <= tload(EOI_WAIT);
            end else begin
              idx        <= 3'd0;
              iec_clk_o  <= 1'b0;
              iec_data_o <= data_q[0];
              state      <= BIT_LO;
              timer      <= tload(BIT_LO);
            end
          end
        end
        EOI_WAIT: begin
          if (!data_s) begin
            state <= EOI_ACK;
            timer <= tload(EOI_ACK);
          end
        end
        EOI_ACK: begin
          if (data_s) begin
            idx        <= 3'd0;
            iec_clk_o  <= 1'b0;
            iec_data_o <= data_q[0];
            state      <= BIT_LO;
            timer      <= tload(BIT_LO);
          end
        end
        BIT_LO: begin
          if (timer == 11'd0) begin
            iec_clk_o <= 1'b1;
            state     <= BIT_HI;
            timer     <= tload(BIT_HI);
          end
        end
        BIT_HI: begin
          if (timer == 11'd0) begin
            iec_clk_o <= 1'b0;
            if (idx == 3'd7) begin
              iec_data_o <= 1'b1;
              state      <= FRAME;
              timer      <= tload(FRAME);
            end else begin
              idx        <= idx + 3'd1;
              iec_data_o <= data_q[idx + 3'd1];
              state      <= BIT_LO;
              timer      <= tload(BIT_LO);
            end
          end
        end
        FRAME: begin
          if (timer == 11'd0) begin
            state <= ACK_WAIT;
            timer <= tload(ACK_WAIT);
          end
        end
        ACK_WAIT: begin
          if (!data_s) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
            timer <= tload(IDLE);
          end
`ifdef IEC_HOST_TIMEOUT_EN
          else if (timer == 11'd0) begin
            err_noack  <= 1'b1;
            iec_atn_o  <= 1'b1;
            iec_clk_o  <= 1'b1;
            iec_data_o <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
            timer      <= tload(IDLE);
          end
`endif
        end
        default: begin
          state <= IDLE;
          timer <= tload(IDLE);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iec_host_tx.sv
// tb_iec_host_tx: directed/randomized bench for iec_host_tx with a behavioural listener.
// ce pulses every other clk, so 1 us of protocol time is 2 clk cycles here.
// Expected bytes, bit timing and flag behaviour come from the protocol rules.
`timescale 1ns/1ps
module tb_iec_host_tx;
  logic clk = 1'b0, reset_n = 1'b0, ce = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic tx_atn = 1'b0, tx_eoi = 1'b0, tx_valid = 1'b0, atn_release = 1'b0;
  logic iec_atn_i, iec_clk_i, iec_data_i;
  logic iec_atn_o, iec_clk_o, iec_data_o;
  logic tx_ready, busy, done, err_nodev, err_noack;
  logic lst_data = 1'b1;
  int nvec = 0, nerr = 0;

  // Wired-AND bus: host drives plus one listener pulling DATA.
  assign iec_atn_i  = iec_atn_o;
  assign iec_clk_i  = iec_clk_o;
  assign iec_data_i = iec_data_o & lst_data;

  iec_host_tx dut (
    .clk(clk), .reset_n(reset_n), .ce(ce),
    .tx_data(tx_data), .tx_atn(tx_atn), .tx_eoi(tx_eoi), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .atn_release(atn_release),
    .iec_atn_i(iec_atn_i), .iec_clk_i(iec_clk_i), .iec_data_i(iec_data_i),
    .iec_atn_o(iec_atn_o), .iec_clk_o(iec_clk_o), .iec_data_o(iec_data_o),
    .busy(busy), .done(done), .err_nodev(err_nodev), .err_noack(err_noack)
  );

  always #5 clk = ~clk;
  always @(negedge clk) ce = ~ce;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int v, input int lo, input int hi);
    nvec++;
    assert (v >= lo && v <= hi) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, v, lo, hi);
    end
  endtask

  task automatic wait_clk_lvl(input logic lvl, input int lim, output int n);
    n = 0;
    while (iec_clk_o !== lvl && n < lim) begin @(negedge clk); n++; end
  endtask

  task automatic send(input logic [7:0] d, input bit atn, input bit eoi);
    int n;
    @(negedge clk);
    tx_data = d; tx_atn = atn; tx_eoi = eoi; tx_valid = 1'b1;
    n = 0;
    while (tx_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("accept", n < 100, 1);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Listener: answers ATN, signals ready-for-data, detects EOI by the talker's
  // delay, captures 8 bits on CLK rising edges and optionally acks the frame.
  task automatic listen(input bit cmd, input bit eoi, input bit ack, input logic [7:0] exp);
    int n, lo, hi;
    logic [7:0] got;
    bit atn_bad;
    got = 8'h00; atn_bad = 1'b0;
    if (cmd) begin
      n = 0;
      while (iec_atn_o !== 1'b0 && n < 100) begin @(negedge clk); n++; end
      chk("atn_asserted", n < 100, 1);
      repeat (2 * $urandom_range(5, 100)) @(negedge clk);
      lst_data = 1'b0;
    end
    wait_clk_lvl(1'b1, 4000, n);
    chk("clk_released", n < 4000, 1);
    repeat (2 * $urandom_range(1, 40)) @(negedge clk);
    lst_data = 1'b1;
    if (eoi) begin
      n = 0;
      for (int k = 0; k < 400; k++) begin
        @(negedge clk);
        if (iec_clk_o !== 1'b1) n++;
      end
      chk("eoi_clk_held", n, 0);
      lst_data = 1'b0;
      repeat (120) @(negedge clk);
      lst_data = 1'b1;
    end
    wait_clk_lvl(1'b0, 12, n);
    chk("bit_start_latency", n < 12, 1);
    for (int i = 0; i < 8; i++) begin
      wait_clk_lvl(1'b0, 20, n);
      lo = 0;
      while (iec_clk_o === 1'b0 && lo < 400) begin @(negedge clk); lo++; end
      chk_rng("bit_lo_time", lo, 118, 124);
      got[i] = iec_data_i;
      if (iec_atn_o !== !cmd) atn_bad = 1'b1;
      hi = 0;
      while (iec_clk_o === 1'b1 && hi < 400) begin @(negedge clk); hi++; end
      chk_rng("bit_hi_time", hi, 118, 124);
    end
    chk("byte_bits", got, exp);
    chk("atn_during_bits", atn_bad, 0);
    if (ack) begin
      repeat (2 * $urandom_range(5, 50)) @(negedge clk);
      lst_data = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] d, input bit cmd, input bit eoi);
    int n;
    fork
      send(d, cmd, eoi);
      listen(cmd, eoi, 1'b1, d);
    join
    n = 0;
    while (done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("done_seen", done, 1);
    chk("busy_clear", busy, 0);
    @(negedge clk);
    chk("done_one_clk", done, 0);
    chk("ready_again", tx_ready, 1);
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int n, rises;
    logic prev;
    logic [7:0] rb;

    // Reset state
    repeat (4) @(negedge clk);
    chk("rst_outs", {iec_atn_o, iec_clk_o, iec_data_o}, 3'b111);
    chk("rst_flags", {tx_ready, busy, done, err_nodev, err_noack}, 5'b00000);
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", tx_ready, 1);

    // Command byte under ATN
    xfer(8'h28, 1'b1, 1'b0);
    chk("atn_kept_after_cmd", iec_atn_o, 0);
    chk("clk_low_after_cmd", iec_clk_o, 0);

    // Turnaround: drop ATN, hold CLK as talker
    atn_release = 1'b1;
    @(negedge clk);
    atn_release = 1'b0;
    chk("atn_release_lines", {iec_atn_o, iec_clk_o}, 2'b10);

    // Data bytes without and with EOI
    xfer(8'h41, 1'b0, 1'b0);
    xfer(8'h0D, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      rb = 8'($urandom);
      xfer(rb, 1'b0, 1'($urandom_range(0, 1)));
    end

    // Random command followed by turnaround
    rb = 8'($urandom);
    xfer(rb, 1'b1, 1'b0);
    @(negedge clk); atn_release = 1'b1;
    @(negedge clk); atn_release = 1'b0;
    chk("atn_release_2", {iec_atn_o, iec_clk_o}, 2'b10);

    // No device present
    lst_data = 1'b1;
    send(8'h3F, 1'b1, 1'b0);
`ifdef IEC_HOST_TIMEOUT_EN
    n = 0;
    while (err_nodev !== 1'b1 && n < 2400) begin @(negedge clk); n++; end
    chk_rng("nodev_time", n, 1990, 2010);
    chk("nodev_lines", {iec_atn_o, iec_clk_o, iec_data_o}, 3'b111);
    chk("nodev_busy", busy, 0);
    @(negedge clk);
    chk("nodev_ready", tx_ready, 1);
`else
    repeat (2400) @(negedge clk);
    chk("nodev_wait_busy", busy, 1);
    chk("nodev_wait_flag", err_nodev, 0);
    chk("nodev_wait_atn", iec_atn_o, 0);
    pulse_reset();
`endif

    // Listener never acknowledges the frame
    lst_data = 1'b1;
    rb = 8'($urandom);
    fork
      send(rb, 1'b1, 1'b0);
      listen(1'b1, 1'b0, 1'b0, rb);
    join
`ifdef IEC_HOST_TIMEOUT_EN
    n = 0;
    while (err_noack !== 1'b1 && n < 2400) begin @(negedge clk); n++; end
    chk_rng("noack_time", n, 1990, 2012);
    chk("noack_lines", {iec_atn_o, iec_clk_o, iec_data_o}, 3'b111);
    chk("noack_busy", busy, 0);
`else
    repeat (2400) @(negedge clk);
    chk("noack_wait_busy", busy, 1);
    chk("noack_wait_flag", err_noack, 0);
    chk("noack_wait_clk", iec_clk_o, 0);
    pulse_reset();
`endif

    // Reset in the high phase of bit 3
    lst_data = 1'b1;
    send(8'hA5, 1'b0, 1'b0);
    rises = 0; prev = iec_clk_o; n = 0;
    while (rises < 4 && n < 2000) begin
      @(negedge clk); n++;
      if (prev === 1'b0 && iec_clk_o === 1'b1) rises++;
      prev = iec_clk_o;
    end
    chk("reach_bit3_hi", rises, 4);
    repeat (20) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_lines", {iec_atn_o, iec_clk_o, iec_data_o}, 3'b111);
    chk("midrst_flags", {tx_ready, busy, done, err_nodev, err_noack}, 5'b00000);
    reset_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready", tx_ready, 1);
    lst_data = 1'b0;
    rb = 8'($urandom);
    xfer(rb, 1'b0, 1'($urandom_range(0, 1)));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
